// File: rtl/desafio_pkg.sv
// desafio_pkg: shared types and constants for the challenge-generator game blocks.
//   estado_t   : game FSM states
//   RES_*      : comparator result codes (anything other than RES_ACERTO is a miss)
//   LFSR_W/TAPS: 8-bit Fibonacci LFSR, taps 8,6,5,4
//   lfsr_next  : one LFSR step
package desafio_pkg;

  typedef enum logic [1:0] {OCIOSO, SORTEIA, AGUARDA, FIM} estado_t;

  localparam logic [1:0] RES_ACERTO = 2'b00;
  localparam logic [1:0] RES_ERRO   = 2'b01;

  localparam int             LFSR_W    = 8;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;  // bits 7,5,4,3 = taps 8,6,5,4

  // Shift left, feedback = parity of tapped bits enters at bit 0.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
    return {v[LFSR_W-2:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr_desafio.sv
// lfsr_desafio: free-running 8-bit Fibonacci LFSR shared by the game blocks.
//   clk      in  clock, advances on every rising edge outside reset
//   rst      in  async active-high reset, loads RST_VAL
//   carregar in  load semente instead of advancing
//   semente  in  value loaded by carregar
//   valor    out current LFSR value
module lfsr_desafio
  import desafio_pkg::*;
#(
  parameter logic [LFSR_W-1:0] RST_VAL = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              carregar,
  input  logic [LFSR_W-1:0] semente,
  output logic [LFSR_W-1:0] valor
);

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = carregar ? semente : lfsr_next(lfsr_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= RST_VAL;
    else     lfsr_q <= lfsr_d;
  end

  assign valor = lfsr_q;

endmodule

// File: rtl/gerador_desafio.sv
// gerador_desafio: producer side of the comparator interface. Draws secret bits
// A_Pin/B_Pin and mode modoB from an LFSR each round, waits for the player's
// confirma strobe, scores resultado and stops after N_RODADAS rounds.
//   clk, rst         clock, async active-high reset
//   iniciar          start/restart (accepted in OCIOSO or FIM only)
//   confirma         one-cycle attempt strobe (accepted in AGUARDA only)
//   resultado[1:0]   comparator code, 2'b00 = hit
//   A_Pin,B_Pin,modoB secret bits and compare mode, latched in SORTEIA
//   acertos,erros,rodada  per-game counters
//   ativo, fim_jogo  status flags
// Optional: define GERADOR_TIMEOUT_EN to score a miss after TIMEOUT_CICLOS
// cycles in AGUARDA without confirma.
module gerador_desafio
  import desafio_pkg::*;
#(
  parameter int                N_RODADAS      = 8,
  parameter logic [LFSR_W-1:0] SEED           = 8'hA5,
  parameter int                TIMEOUT_CICLOS = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iniciar,
  input  logic       confirma,
  input  logic [1:0] resultado,
  output logic       A_Pin,
  output logic       B_Pin,
  output logic       modoB,
  output logic [3:0] acertos,
  output logic [3:0] erros,
  output logic [3:0] rodada,
  output logic       ativo,
  output logic       fim_jogo
);

  if (N_RODADAS < 1 || N_RODADAS > 15) begin : g_bad_rodadas
    $error("N_RODADAS must be 1..15");
  end
  if (SEED == '0) begin : g_bad_seed
    $error("SEED must be nonzero");
  end
  if (TIMEOUT_CICLOS < 1) begin : g_bad_timeout
    $error("TIMEOUT_CICLOS must be >= 1");
  end

  estado_t           estado_q, estado_d;
  logic [3:0]        acertos_q, acertos_d, erros_q, erros_d, rodada_q, rodada_d;
  logic [2:0]        pinos_q, pinos_d;   // {modoB, B, A}
  logic              carregar;
  logic [LFSR_W-1:0] lfsr_val;
  logic              tempo_esgotado;

  lfsr_desafio #(.RST_VAL(SEED)) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .carregar (carregar),
    .semente  (SEED),
    .valor    (lfsr_val)
  );

`ifdef GERADOR_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CICLOS) + 1;
  logic [TMR_W-1:0] tmr_q, tmr_d;

  assign tempo_esgotado = (tmr_q == TMR_W'(TIMEOUT_CICLOS - 1));

  // Cleared while in SORTEIA so every AGUARDA entry starts at zero.
  always_comb begin
    tmr_d = '0;
    if (estado_q == AGUARDA) tmr_d = tmr_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tmr_q <= '0;
    else     tmr_q <= tmr_d;
  end
`else
  assign tempo_esgotado = 1'b0;
`endif

  always_comb begin
    estado_d  = estado_q;
    acertos_d = acertos_q;
    erros_d   = erros_q;
    rodada_d  = rodada_q;
    pinos_d   = pinos_q;
    carregar  = 1'b0;
    case (estado_q)
      OCIOSO, FIM: begin
        if (iniciar) begin
          estado_d  = SORTEIA;
          acertos_d = '0;
          erros_d   = '0;
          rodada_d  = '0;
          carregar  = 1'b1;
        end
      end
      SORTEIA: begin
        pinos_d  = lfsr_val[2:0];
        estado_d = AGUARDA;
      end
      AGUARDA: begin
        // confirma wins over a simultaneous timeout and is scored by resultado.
        if (confirma || tempo_esgotado) begin
          if (confirma && resultado == RES_ACERTO) acertos_d = acertos_q + 1'b1;
          else                                     erros_d   = erros_q + 1'b1;
          rodada_d = rodada_q + 1'b1;
          estado_d = (rodada_q + 4'd1 == 4'(N_RODADAS)) ? FIM : SORTEIA;
        end
      end
      default: estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q  <= OCIOSO;
      acertos_q <= '0;
      erros_q   <= '0;
      rodada_q  <= '0;
      pinos_q   <= '0;
    end else begin
      estado_q  <= estado_d;
      acertos_q <= acertos_d;
      erros_q   <= erros_d;
      rodada_q  <= rodada_d;
      pinos_q   <= pinos_d;
    end
  end

  assign A_Pin    = pinos_q[0];
  assign B_Pin    = pinos_q[1];
  assign modoB    = pinos_q[2];
  assign acertos  = acertos_q;
  assign erros    = erros_q;
  assign rodada   = rodada_q;
  assign ativo    = (estado_q == SORTEIA) || (estado_q == AGUARDA);
  assign fim_jogo = (estado_q == FIM);

endmodule

// File: tb/tb_gerador_desafio.sv
module tb_gerador_desafio;

  localparam int N = 8;
  localparam int TMO = 10;
  localparam logic [7:0] SEED = 8'hA5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic iniciar = 1'b0, confirma = 1'b0;
  logic [1:0] resultado = 2'b00;
  logic A_Pin, B_Pin, modoB, ativo, fim_jogo;
  logic [3:0] acertos, erros, rodada;

  int nchk = 0;
  int nerr = 0;

  // Reference model: game phase 0=idle,1=draw,2=wait,3=done
  int m_ph, m_ac, m_er, m_rod, m_t;
  int m_lfsr;
  int m_a, m_b, m_m;

  gerador_desafio #(.N_RODADAS(N), .SEED(SEED), .TIMEOUT_CICLOS(TMO)) dut (
    .clk(clk), .rst(rst), .iniciar(iniciar), .confirma(confirma),
    .resultado(resultado), .A_Pin(A_Pin), .B_Pin(B_Pin), .modoB(modoB),
    .acertos(acertos), .erros(erros), .rodada(rodada),
    .ativo(ativo), .fim_jogo(fim_jogo)
  );

  always #5 clk = ~clk;

  function automatic int lfsr_step(input int v);
    int fb;
    fb = ((v >> 7) ^ (v >> 5) ^ (v >> 4) ^ (v >> 3)) & 1;
    return ((v << 1) | fb) & 255;
  endfunction

  task automatic m_reset();
    m_ph = 0; m_ac = 0; m_er = 0; m_rod = 0; m_t = 0;
    m_lfsr = int'(SEED); m_a = 0; m_b = 0; m_m = 0;
  endtask

  task automatic m_step(input bit i, input bit c, input int r);
    int nl;
    bit tmo;
    nl = lfsr_step(m_lfsr);
`ifdef GERADOR_TIMEOUT_EN
    tmo = (m_t == TMO - 1);
`else
    tmo = 1'b0;
`endif
    if (m_ph == 0 || m_ph == 3) begin
      if (i) begin
        m_ph = 1; m_ac = 0; m_er = 0; m_rod = 0; nl = int'(SEED);
      end
    end else if (m_ph == 1) begin
      m_a = m_lfsr & 1; m_b = (m_lfsr >> 1) & 1; m_m = (m_lfsr >> 2) & 1;
      m_ph = 2; m_t = 0;
    end else begin
      if (c || tmo) begin
        if (c && r == 0) m_ac++; else m_er++;
        m_rod++;
        m_ph = (m_rod == N) ? 3 : 1;
      end else begin
        m_t++;
      end
    end
    m_lfsr = nl;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("A_Pin", int'(A_Pin), m_a);
    chk("B_Pin", int'(B_Pin), m_b);
    chk("modoB", int'(modoB), m_m);
    chk("acertos", int'(acertos), m_ac);
    chk("erros", int'(erros), m_er);
    chk("rodada", int'(rodada), m_rod);
    chk("ativo", int'(ativo), int'(m_ph == 1 || m_ph == 2));
    chk("fim_jogo", int'(fim_jogo), int'(m_ph == 3));
  endtask

  // Drive inputs just after an edge, take one edge, check 1 time unit later.
  task automatic tick(input bit i, input bit c, input logic [1:0] r);
    iniciar = i; confirma = c; resultado = r;
    @(posedge clk);
    if (!rst) m_step(i, c, int'(r));
    #1;
    chk_all();
  endtask

  // Starting in AGUARDA: idle a bit, confirm, then pass SORTEIA if not done.
  task automatic rodada_jogo(input logic [1:0] r);
    int idle;
    idle = $urandom_range(0, 2);
    for (int k = 0; k < idle; k++) tick(0, 0, 2'b00);
    tick(0, 1, r);
    if (m_ph == 1) tick(0, 0, 2'b00);
  endtask

  initial begin
    m_reset();
    #2;
    chk_all();                       // reset values
    @(posedge clk); #3; rst = 1'b0;  // release between edges
    @(posedge clk); m_step(0, 0, 0); #1; chk_all();

    // confirma in OCIOSO ignored
    tick(0, 1, 2'b00);
    chk("ocioso_rodada", int'(rodada), 0);

    // 1: iniciar -> ativo; following edge pins from SEED bits [2:0]
    tick(1, 0, 2'b00);
    chk("ativo_after_iniciar", int'(ativo), 1);
    tick(0, 0, 2'b00);
    chk("pins_from_seed", int'({modoB, B_Pin, A_Pin}), int'(SEED) & 7);

    // 2: eight hits
    for (int k = 0; k < N; k++) rodada_jogo(2'b00);
    chk("t2_acertos", int'(acertos), 8);
    chk("t2_erros", int'(erros), 0);
    chk("t2_rodada", int'(rodada), 8);
    chk("t2_fim", int'(fim_jogo), 1);
    chk("t2_ativo", int'(ativo), 0);

    // 4: confirma in FIM ignored
    tick(0, 1, 2'b00);
    chk("fim_frozen", int'(acertos), 8);

    // 3: restart from FIM, codes 00/01/10/11 in turn
    tick(1, 0, 2'b00);
    tick(0, 1, 2'b00);               // confirma in SORTEIA ignored
    chk("sorteia_confirma", int'(rodada), 0);
    tick(1, 0, 2'b00);               // iniciar in AGUARDA ignored
    chk("aguarda_iniciar_ativo", int'(ativo), 1);
    for (int k = 0; k < N; k++) rodada_jogo(2'(k % 4));
    chk("t3_acertos", int'(acertos), 2);
    chk("t3_erros", int'(erros), 6);

    // 5: async reset mid round 5
    tick(1, 0, 2'b00);
    tick(0, 0, 2'b00);
    for (int k = 0; k < 4; k++) rodada_jogo(2'($urandom_range(0, 3)));
    tick(0, 0, 2'b00);
    #2; rst = 1'b1; #1;
    m_reset();
    chk_all();
    chk("rst_async_rodada", int'(rodada), 0);
    tick(0, 1, 2'b00);               // edge under reset: nothing moves
    #2; rst = 1'b0;
    tick(1, 0, 2'b00);
    tick(0, 0, 2'b00);
    chk("fresh_rodada", int'(rodada), 0);

`ifdef GERADOR_TIMEOUT_EN
    // 6: timeout scores a miss; confirma on the last cycle wins
    begin
      int e0, a0;
      e0 = int'(erros); a0 = int'(acertos);
      for (int k = 0; k < TMO - 1; k++) tick(0, 0, 2'b00);
      chk("tmo_before", int'(erros), e0);
      tick(0, 0, 2'b00);
      chk("tmo_miss", int'(erros), e0 + 1);
      tick(0, 0, 2'b00);
      for (int k = 0; k < TMO - 1; k++) tick(0, 0, 2'b00);
      tick(0, 1, 2'b00);
      chk("tmo_confirma_hit", int'(acertos), a0 + 1);
      chk("tmo_confirma_err", int'(erros), e0 + 1);
    end
`endif

    // randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      tick($urandom_range(0, 9) == 0, $urandom_range(0, 9) < 4,
           2'($urandom_range(0, 3)));
      chk("invariant", int'(acertos) + int'(erros), int'(rodada));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
